// File: rtl/timer_pkg.sv
// Shared defaults, channel state type and the pending-channel priority encoder
// for the millisecond timer scheduler.
package timer_pkg;

   localparam int unsigned DEF_CLK_DIV = 50000;
   localparam int unsigned DEF_NUM_CH  = 4;
   localparam int unsigned DEF_CNT_W   = 16;
   localparam int unsigned CH_W        = $clog2(DEF_NUM_CH);

   typedef logic [DEF_CNT_W-1:0] cnt_t;

   typedef struct packed {
      cnt_t cnt;
      cnt_t period;
      logic en;
      logic periodic;
   } chan_t;

   // Index of the lowest set bit; 0 when nothing is set (up to 8 channels)
   function automatic logic [2:0] prio_enc(input logic [7:0] pend);
      logic [2:0] idx;
      idx = '0;
      for (int i = 7; i >= 0; i--) begin
         if (pend[i]) idx = 3'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/timer_sched_if.sv
// CPU-side configuration, readback and interrupt handshake bundle of timer_sched.
interface timer_sched_if
   import timer_pkg::*;
#(
   parameter int unsigned NUM_CH = DEF_NUM_CH,
   parameter int unsigned CNT_W  = DEF_CNT_W
);
   localparam int unsigned IDX_W = $clog2(NUM_CH);

   logic              cfg_we;
   logic [IDX_W-1:0]  cfg_ch;
   logic [CNT_W-1:0]  cfg_period;
   logic              cfg_en;
   logic              cfg_periodic;
   logic [IDX_W-1:0]  rd_ch;
   logic [CNT_W-1:0]  rd_cnt;
   logic              tick;
   logic              irq;
   logic [IDX_W-1:0]  irq_ch;
   logic              irq_ack;
   logic [NUM_CH-1:0] ovf;

   modport master (
      output cfg_we, cfg_ch, cfg_period, cfg_en, cfg_periodic, rd_ch, irq_ack,
      input  rd_cnt, tick, irq, irq_ch, ovf
   );

   modport slave (
      input  cfg_we, cfg_ch, cfg_period, cfg_en, cfg_periodic, rd_ch, irq_ack,
      output rd_cnt, tick, irq, irq_ch, ovf
   );

endinterface

// File: rtl/timer_prescaler.sv
// Free-running divider producing a one-cycle enable every CLK_DIV clocks.
module timer_prescaler
   import timer_pkg::*;
#(
   parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);
   localparam int unsigned PW = $clog2(CLK_DIV);

   logic [PW-1:0] r_cnt;
   logic          r_tick;
   logic          w_wrap;

   assign w_wrap = (r_cnt == PW'(CLK_DIV - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt  <= '0;
         r_tick <= 1'b0;
      end else begin
         r_tick <= w_wrap;
         r_cnt  <= w_wrap ? '0 : r_cnt + PW'(1);
      end
   end

   assign tick = r_tick;

endmodule

// File: rtl/timer_sched.sv
// Multi-channel tick-driven down-counters with latched expiries, presented to
// the CPU lowest channel first through an acknowledge handshake.
module timer_sched
   import timer_pkg::*;
#(
   parameter int unsigned CLK_DIV = DEF_CLK_DIV,
   parameter int unsigned NUM_CH  = DEF_NUM_CH,
   parameter int unsigned CNT_W   = DEF_CNT_W
) (
   input logic           clk,
   input logic           rst,
   timer_sched_if.slave  bus
);
   localparam int unsigned IDX_W = $clog2(NUM_CH);

   logic             w_tick;
   logic [NUM_CH-1:0] w_pend;
   logic [NUM_CH-1:0] w_ovf;
   logic [CNT_W-1:0] w_cnt [NUM_CH];
   logic             r_irq;
   logic [IDX_W-1:0] r_irq_ch;

   timer_prescaler #(.CLK_DIV(CLK_DIV)) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .tick (w_tick)
   );

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      chan_t r_st;
      logic  r_pend;
      logic  r_ovf;
      logic  w_cfg;
      logic  w_ack;
      logic  w_exp;

      assign w_cfg = bus.cfg_we && (bus.cfg_ch == IDX_W'(gi));
      assign w_ack = bus.irq_ack && r_irq && (r_irq_ch == IDX_W'(gi));
      assign w_exp = w_tick && r_st.en && (r_st.cnt == cnt_t'(1));

      // A config write overrides both the tick and an acknowledge on this channel
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_st   <= '0;
            r_pend <= 1'b0;
            r_ovf  <= 1'b0;
         end else if (w_cfg) begin
            r_st.cnt      <= cnt_t'(bus.cfg_period);
            r_st.period   <= cnt_t'(bus.cfg_period);
            r_st.en       <= bus.cfg_en && (bus.cfg_period != '0);
            r_st.periodic <= bus.cfg_periodic;
            r_pend        <= 1'b0;
            r_ovf         <= 1'b0;
         end else begin
            if (w_tick && r_st.en) begin
               if (r_st.cnt > cnt_t'(1)) begin
                  r_st.cnt <= r_st.cnt - cnt_t'(1);
               end else if (w_exp) begin
                  if (r_st.periodic) begin
                     r_st.cnt <= r_st.period;
                  end else begin
                     r_st.cnt <= '0;
                     r_st.en  <= 1'b0;
                  end
               end
            end
            // An ack in the expiry cycle consumes the older event, so no overrun
            r_pend <= w_exp | (r_pend & ~w_ack);
            r_ovf  <= ~w_ack & (r_ovf | (w_exp & r_pend));
         end
      end

      assign w_cnt[gi]  = CNT_W'(r_st.cnt);
      assign w_pend[gi] = r_pend;
      assign w_ovf[gi]  = r_ovf;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_irq    <= 1'b0;
         r_irq_ch <= '0;
      end else begin
         r_irq    <= |w_pend;
         r_irq_ch <= IDX_W'(prio_enc(8'(w_pend)));
      end
   end

   assign bus.tick   = w_tick;
   assign bus.irq    = r_irq;
   assign bus.irq_ch = r_irq_ch;
   assign bus.ovf    = w_ovf;
   assign bus.rd_cnt = w_cnt[bus.rd_ch];

endmodule

// File: tb/tb_timer_sched.sv
// Directed bench for timer_sched: a spec-level cycle model checked every cycle,
// plus hand-computed latency and boundary expectations.
module tb_timer_sched;
   import timer_pkg::*;

   localparam int CLK_DIV = 4;
   localparam int NUM_CH  = 4;
   localparam int CNT_W   = 16;
   localparam int IW      = 2;

   logic clk = 1'b0;
   logic rst = 1'b0;
   bit   cmp_on = 1'b0;
   int   cyc = 0;
   int   n_pass = 0;
   int   n_total = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   timer_sched_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

   timer_sched #(.CLK_DIV(CLK_DIV), .NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   // Model: every edge counted since reset; a tick is visible in each cycle
   // that follows a multiple of CLK_DIV edges.
   int m_edges;
   int m_cnt  [NUM_CH];
   int m_per  [NUM_CH];
   bit m_en   [NUM_CH];
   bit m_perd [NUM_CH];
   bit m_pend [NUM_CH];
   bit m_ovf  [NUM_CH];
   bit m_irq;
   int m_irq_ch;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_edges = 0;
         for (int c = 0; c < NUM_CH; c++) begin
            m_cnt[c] = 0; m_per[c] = 0; m_en[c] = 0;
            m_perd[c] = 0; m_pend[c] = 0; m_ovf[c] = 0;
         end
         m_irq = 0;
         m_irq_ch = 0;
      end else begin
         bit tk, any, fire, was;
         int ack_ch, first;
         tk = (m_edges > 0) && (m_edges % CLK_DIV == 0);
         ack_ch = (bus.irq_ack && m_irq) ? m_irq_ch : -1;
         any = 0;
         first = 0;
         for (int c = 0; c < NUM_CH; c++) begin
            if (m_pend[c] && !any) begin any = 1; first = c; end
         end
         for (int c = 0; c < NUM_CH; c++) begin
            if (bus.cfg_we && int'(bus.cfg_ch) == c) begin
               m_cnt[c]  = int'(bus.cfg_period);
               m_per[c]  = int'(bus.cfg_period);
               m_en[c]   = bus.cfg_en && (bus.cfg_period != '0);
               m_perd[c] = bus.cfg_periodic;
               m_pend[c] = 0;
               m_ovf[c]  = 0;
            end else begin
               was  = m_pend[c];
               fire = tk && m_en[c] && (m_cnt[c] == 1);
               if (ack_ch == c) begin m_pend[c] = 0; m_ovf[c] = 0; end
               if (tk && m_en[c] && m_cnt[c] > 1) m_cnt[c] = m_cnt[c] - 1;
               if (fire) begin
                  if (was && ack_ch != c) m_ovf[c] = 1;
                  m_pend[c] = 1;
                  if (m_perd[c]) m_cnt[c] = m_per[c];
                  else begin m_cnt[c] = 0; m_en[c] = 0; end
               end
            end
         end
         m_irq = any;
         m_irq_ch = first;
         m_edges++;
      end
   end

   always @(negedge clk) begin
      if (!rst && cmp_on) begin
         logic [NUM_CH-1:0] e_ovf;
         for (int c = 0; c < NUM_CH; c++) e_ovf[c] = m_ovf[c];
         chk("cyc_tick",   32'(bus.tick), 32'((m_edges > 0) && (m_edges % CLK_DIV == 0)));
         chk("cyc_irq",    32'(bus.irq), 32'(m_irq));
         chk("cyc_irq_ch", 32'(bus.irq_ch), m_irq_ch);
         chk("cyc_ovf",    32'(bus.ovf), 32'(e_ovf));
         chk("cyc_rd_cnt", 32'(bus.rd_cnt), m_cnt[int'(bus.rd_ch)]);
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic cfg(input int ch, input int per, input bit en, input bit perd);
      bus.cfg_we       = 1'b1;
      bus.cfg_ch       = IW'(ch);
      bus.cfg_period   = CNT_W'(per);
      bus.cfg_en       = en;
      bus.cfg_periodic = perd;
      step(1);
      bus.cfg_we       = 1'b0;
   endtask

   task automatic ack();
      bus.irq_ack = 1'b1;
      step(1);
      bus.irq_ack = 1'b0;
   endtask

   task automatic wait_tick();
      int n = 0;
      do begin step(1); n++; end while (!bus.tick && n < 10);
      chk("tick_seen", 32'(bus.tick), 1);
   endtask

   task automatic wait_irq(input string name, input int exp_n);
      int n = 0;
      while (!bus.irq && n < 60) begin step(1); n++; end
      chk(name, n, exp_n);
   endtask

   initial begin
      int n, t1, t2;
      bus.cfg_we = 0; bus.cfg_ch = '0; bus.cfg_period = '0; bus.cfg_en = 0;
      bus.cfg_periodic = 0; bus.rd_ch = '0; bus.irq_ack = 0;
      #2 rst = 1'b1;
      #1;
      chk("rst_irq", 32'(bus.irq), 0);
      chk("rst_irq_ch", 32'(bus.irq_ch), 0);
      chk("rst_ovf", 32'(bus.ovf), 0);
      chk("rst_tick", 32'(bus.tick), 0);
      chk("rst_rd_cnt", 32'(bus.rd_cnt), 0);
      step(2);
      rst = 1'b0;
      cmp_on = 1'b1;
      step(3);
      chk("tick_before_4", 32'(bus.tick), 0);
      step(1);
      chk("tick_at_4", 32'(bus.tick), 1);

      // One-shot ch2, period 3, written the cycle after a tick
      step(1);
      cfg(2, 3, 1, 0);
      bus.rd_ch = 2'd2;
      chk("oneshot_load", 32'(bus.rd_cnt), 3);
      wait_irq("oneshot_latency", 12);
      chk("oneshot_irq_ch", 32'(bus.irq_ch), 2);
      chk("oneshot_cnt_done", 32'(bus.rd_cnt), 0);
      step(20);
      chk("oneshot_hold_irq", 32'(bus.irq), 1);
      chk("oneshot_no_ovf", 32'(bus.ovf), 0);
      ack();
      chk("ack_lag_irq", 32'(bus.irq), 1);
      step(1);
      chk("ack_clear_irq", 32'(bus.irq), 0);

      // Periodic ch1 and ch3, period 2, same prescaler phase
      wait_tick();
      step(1);
      cfg(1, 2, 1, 1);
      cfg(3, 2, 1, 1);
      wait_irq("periodic_latency", 7);
      t1 = cyc;
      chk("prio_first", 32'(bus.irq_ch), 1);
      ack();
      chk("prio_ack_lag", 32'(bus.irq_ch), 1);
      step(1);
      chk("prio_next", 32'(bus.irq_ch), 3);
      chk("prio_irq_held", 32'(bus.irq), 1);
      ack();
      chk("prio_ack2_lag", 32'(bus.irq), 1);
      step(1);
      chk("prio_all_clear", 32'(bus.irq), 0);
      wait_irq("periodic_reexpire", 4);
      t2 = cyc;
      chk("periodic_interval", t2 - t1, 8);
      chk("reexpire_irq_ch", 32'(bus.irq_ch), 1);

      // Disable: period 0 with en=1 must stay off
      cfg(1, 0, 1, 1);
      bus.rd_ch = 2'd1;
      chk("disable_rd_cnt", 32'(bus.rd_cnt), 0);
      cfg(3, 0, 0, 0);
      step(40);
      chk("disable_quiet", 32'(bus.irq), 0);
      chk("disable_rd_cnt_late", 32'(bus.rd_cnt), 0);

      // Overrun on ch0 periodic period 1, then ack coincident with re-expiry
      bus.rd_ch = 2'd0;
      wait_tick();
      step(1);
      cfg(0, 1, 1, 1);
      n = 0;
      while (!bus.ovf[0] && n < 60) begin step(1); n++; end
      chk("ovf_latency", n, 7);
      chk("ovf_irq_ch", 32'(bus.irq_ch), 0);
      ack();
      chk("ovf_ack_clear", 32'(bus.ovf), 0);
      step(1);
      chk("ovf_ack_irq", 32'(bus.irq), 0);
      wait_tick();
      wait_tick();
      wait_tick();
      chk("ovf_set_again", 32'(bus.ovf), 1);
      ack();
      chk("ack_on_expiry_ovf", 32'(bus.ovf), 0);
      chk("ack_on_expiry_irq", 32'(bus.irq), 1);
      step(1);
      chk("ack_on_expiry_irq2", 32'(bus.irq), 1);
      chk("ack_on_expiry_ch", 32'(bus.irq_ch), 0);

      // Config coincident with tick wins over the decrement
      wait_tick();
      cfg(0, 5, 1, 0);
      chk("cfg_tick_collide", 32'(bus.rd_cnt), 5);
      wait_tick();
      step(1);
      chk("cfg_then_decr", 32'(bus.rd_cnt), 4);

      // Reset mid-run with ch0 pending
      cfg(0, 1, 1, 1);
      wait_irq("reset_setup", 4);
      rst = 1'b1;
      cmp_on = 1'b0;
      #1;
      chk("midrst_irq", 32'(bus.irq), 0);
      chk("midrst_irq_ch", 32'(bus.irq_ch), 0);
      chk("midrst_ovf", 32'(bus.ovf), 0);
      chk("midrst_tick", 32'(bus.tick), 0);
      chk("midrst_rd_cnt", 32'(bus.rd_cnt), 0);
      step(2);
      rst = 1'b0;
      cmp_on = 1'b1;
      step(3);
      chk("midrst_tick_before_4", 32'(bus.tick), 0);
      step(1);
      chk("midrst_tick_at_4", 32'(bus.tick), 1);
      step(12);
      chk("midrst_no_survival", 32'(bus.irq), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/timer_sched.md
# timer_sched

Multi-channel millisecond timer scheduler for the CPU's interrupt path. A single free-running prescaler produces a 1 ms tick enable, which is shared among NUM_CH independently programmable down-counters. Each counter can be one-shot or periodic. Expiries are latched as pending interrupts and presented to the CPU one channel at a time with an acknowledge handshake.

## Interface
Parameters:
- CLK_DIV, 50000: system-clock cycles per tick (1 ms at 50 MHz); ≥ 2
- NUM_CH, 4: number of timer channels; power of two, 2..8
- CNT_W, 16: counter/period width in ticks

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- cfg_we  in  1  write strobe for channel configuration
- cfg_ch  in  log2(NUM_CH)  channel selected by cfg_we
- cfg_period  in  CNT_W  period in ticks; 0 disables the channel
- cfg_en  in  1  enable the channel
- cfg_periodic  in  1  1 = auto-reload, 0 = one-shot
- rd_ch  in  log2(NUM_CH)  channel for count readback
- rd_cnt  out  CNT_W  remaining ticks of rd_ch (combinational)
- tick  out  1  one-cycle pulse per prescaler wrap
- irq  out  1  OR of all pending bits (registered)
- irq_ch  out  log2(NUM_CH)  lowest-index pending channel (registered)
- irq_ack  in  1  one-cycle acknowledge of irq_ch
- ovf  out  NUM_CH  sticky per-channel overrun flags

## Operation
- Prescaler: counts 0..CLK_DIV-1 and wraps. tick=1 in the cycle after the count equals CLK_DIV-1. It free-runs from reset and is never cleared by a config write.
- Per-channel state: cnt[CNT_W], period[CNT_W], en, periodic, pending, ovf.
- Config write (cfg_we=1):
  - Loads period and cnt from cfg_period, and sets en = cfg_en & (cfg_period≠0).
  - Clears pending and ovf for that channel.
  - Takes effect at the next edge.
- On a tick, for each channel with en=1:
  - If cnt>1: cnt decrements.
  - If cnt==1 (expiry): pending is set. If pending was already set, ovf is also set. Then, if periodic, cnt reloads to period; otherwise cnt=0 and en=0.
- Disabled channels hold cnt unchanged.
- irq = |pending. irq_ch = index of the lowest set pending bit; it is 0 when none is set.
- irq_ack while irq=1 clears pending[irq_ch] and ovf[irq_ch]. irq_ack while irq=0 is ignored.
- Boundary rules:
  - cfg_we and tick on the same channel in the same cycle: config wins; that channel ignores the tick.
  - Expiry and irq_ack on the same channel in the same cycle: pending stays 1; ovf is cleared, then not set (the ack consumed the old event).
  - cfg_we and irq_ack on the same channel in the same cycle: both clear; the result is pending=0.
  - Periodic with period=1: expires on every tick.
  - Counter arithmetic never wraps below 0.

## Timing
- Reset values (asynchronous):
  - prescaler=0, tick=0
  - all cnt/period/en/periodic/pending/ovf=0
  - irq=0, irq_ch=0
- Reset mid-count discards all state; there is no pending survival.
- Write-to-pending latency: pending rises on the edge of the period-th tick after the write, i.e. (period-1)·CLK_DIV+1 to period·CLK_DIV cycles, depending on prescaler phase.
- Pending to irq/irq_ch: +1 cycle (registered).
- irq_ack to irq deassert (or irq_ch update to the next pending): +2 cycles. Pending clears at the ack edge; irq/irq_ch register one cycle later.
- Periodic channel: exactly period·CLK_DIV cycles between successive pending sets.
- rd_cnt reflects the registered cnt with zero latency.

## Structure
- Package timer_pkg holds:
  - default CLK_DIV, NUM_CH, CNT_W
  - the channel-index width localparam
  - a per-channel state struct/typedef (cnt, period, en, periodic)
- Sub-module timer_prescaler (clk, rst → tick), parameterised by CLK_DIV. It is reusable wherever a millisecond enable is needed.
- Channel update logic is a generate loop in timer_sched. The priority encoder for irq_ch is a function in timer_pkg.

## Test plan
All scenarios use CLK_DIV=4, NUM_CH=4, CNT_W=16.
- Reset: assert rst mid-run with ch0 pending → irq=0, irq_ch=0, ovf=0, tick=0 immediately; after release, tick first pulses at cycle 4.
- One-shot: write ch2 period=3, en=1, periodic=0 → pending[2] on the 3rd tick, irq=1 with irq_ch=2 one cycle later; afterwards rd_cnt(ch2)=0 and no further expiries.
- Periodic plus priority: ch1 period=2 and ch3 period=2, both periodic, written in the same phase → both expire together and irq_ch=1. Ack → irq_ch=3 two cycles later. Ack → irq=0. Both re-expire 8 cycles after the previous expiry.
- Overrun: ch0 periodic period=1, never acked → ovf[0]=1 after the 2nd tick. Ack → ovf[0]=0 and pending[0]=0.
- Collisions:
  - cfg_we on ch0 coincident with tick → cnt equals the new period, not period-1.
  - irq_ack coincident with re-expiry of the same channel → irq stays 1 and ovf=0.
- Disable: write ch1 period=0, en=1 → en stays 0, no pending ever, and rd_cnt=0.
